// File: rtl/phase_acc.sv
// Phase accumulator (NCO front end): FTW accumulation, static phase offset,
// glitch-free FTW updates (immediate or at wrap) and a saturating up-chirp sweep.
module phase_acc #(
   parameter int PHASE_W = 21,
   parameter int STEP_W  = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [PHASE_W-1:0] ftw_in,
   input  logic               ftw_wr,
   input  logic               ftw_sync,
   output logic               ftw_busy,
   input  logic [PHASE_W-1:0] phase_ofs,
   input  logic               sweep_start,
   input  logic [STEP_W-1:0]  sweep_step,
   input  logic [PHASE_W-1:0] sweep_stop,
   input  logic               sweep_abort,
   output logic               sweep_done,
   output logic [PHASE_W-1:0] phase_out,
   output logic               phase_valid,
   output logic               wrap
);

   typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

   state_t             state;
   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] ftw_act;
   logic [PHASE_W-1:0] ftw_pend;
   logic               carry_q;

   logic [PHASE_W:0]   sum;
   logic [PHASE_W:0]   sw_sum;
   logic [PHASE_W-1:0] sw_sat;
   logic               start_ok;

   assign sum      = {1'b0, acc} + {1'b0, ftw_act};
   assign sw_sum   = {1'b0, ftw_act} + {{(PHASE_W+1-STEP_W){1'b0}}, sweep_step};
   assign sw_sat   = (sw_sum >= {1'b0, sweep_stop}) ? sweep_stop : sw_sum[PHASE_W-1:0];
   assign start_ok = sweep_start && !sweep_abort && (state != SWEEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         ftw_act     <= '0;
         ftw_pend    <= '0;
         carry_q     <= 1'b0;
         ftw_busy    <= 1'b0;
         sweep_done  <= 1'b0;
         phase_out   <= '0;
         phase_valid <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         sweep_done  <= 1'b0;
         phase_valid <= en;
         wrap        <= en & carry_q;
         // carry is held with acc so wrap lines up with the wrapped value on phase_out
         if (en) begin
            acc       <= sum[PHASE_W-1:0];
            carry_q   <= sum[PHASE_W];
            phase_out <= acc + phase_ofs;
         end

         if (sweep_abort)
            state <= IDLE;

         if (start_ok) begin
            ftw_busy <= 1'b0;
            if (ftw_act >= sweep_stop) begin
               state      <= HOLD;
               sweep_done <= 1'b1;
            end else begin
               state <= SWEEP;
            end
         end else if (state == SWEEP) begin
            if (en && !sweep_abort) begin
               ftw_act <= sw_sat;
               if (sw_sat == sweep_stop) begin
                  state      <= HOLD;
                  sweep_done <= 1'b1;
               end
            end
         end else begin
            // a fresh write overrides a pending one; otherwise pending lands on carry
            if (ftw_wr && !ftw_sync) begin
               ftw_act  <= ftw_in;
               ftw_busy <= 1'b0;
            end else if (ftw_wr) begin
               ftw_pend <= ftw_in;
               ftw_busy <= 1'b1;
            end else if (ftw_busy && en && sum[PHASE_W]) begin
               ftw_act  <= ftw_pend;
               ftw_busy <= 1'b0;
            end
         end
      end
   end

endmodule
